// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : bram_stream_reader
//  Purpose  : Simple dual-port block RAM (DATA_W x 2^ADDR_W) with a per-bit
//             masked write port and a read port that works either as a plain
//             random-access read or as a start/length/loop playback sequencer
//             that streams a contiguous address window one word per enabled
//             cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1       clock for write port, read port and sequencer
//    rst_n      in   1       asynchronous active-low reset
//    wclke      in   1       write clock enable
//    write_en   in   1       write strobe (write when wclke & write_en)
//    waddr      in   ADDR_W  write address
//    din        in   DATA_W  write data
//    mask       in   DATA_W  per-bit write mask, 1 = keep old bit
//    rclke      in   1       read-side enable; low freezes sequencer/pipeline
//    read_en    in   1       random read strobe (mode 0, idle only)
//    raddr      in   ADDR_W  random read address
//    mode       in   1       0 = random access, 1 = playback (sampled at start)
//    start      in   1       playback start pulse, ignored while busy
//    stop       in   1       abort playback (honoured in RUN only)
//    base       in   ADDR_W  first playback address
//    len        in   ADDR_W  playback sample count minus one
//    loop       in   1       restart at base after the last sample
//    dout       out  DATA_W  read data, holds when not updated
//    dout_valid out  1       dout carries a new sample
//    busy       out  1       sequencer in RUN or DRAIN
//    done       out  1       playback completion pulse
// ============================================================================
module bram_stream_reader #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wclke,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] mask,
    input  logic              rclke,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              mode,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    input  logic              loop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              done
);

    localparam int                c_depth    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_one      = {{(ADDR_W-1){1'b0}}, 1'b1};

    localparam logic [1:0]        c_st_idle  = 2'd0;
    localparam logic [1:0]        c_st_run   = 2'd1;
    localparam logic [1:0]        c_st_drain = 2'd2;

    // ------------------------------------------------------------------------
    // Storage and sequencer registers
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [0:c_depth-1];

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic              r_loop;
    logic              w_cnt_zero;

    // Read issue request for the current cycle (qualified by rclke downstream)
    logic              w_issue;
    logic [ADDR_W-1:0] w_issue_addr;
    logic              w_issue_tag;

    // First read pipeline stage: the RAM output register
    logic              r_s1_valid;
    logic              r_s1_tag;
    logic [DATA_W-1:0] r_s1_data;

    // Tag leaving the final pipeline stage: marks the end of a playback
    logic              w_tag_out;

    assign w_cnt_zero = (r_cnt == '0);

    // ------------------------------------------------------------------------
    // Write port. Independent of the read side; memory has no reset so it can
    // map onto block RAM, but writes are suppressed while reset is held.
    // Bits with mask=1 keep their stored value.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && wclke && write_en) begin
            r_mem[waddr] <= (r_mem[waddr] & mask) | (din & ~mask);
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic. Every transition needs rclke because a low rclke
    // freezes the whole read side, including the sequencer.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                // start with mode==0 is ignored
                if (rclke && start && mode) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (rclke) begin
                    // stop wins over a last or loop issue in the same cycle
                    if (stop) begin
                        w_state_nxt = c_st_drain;
                    end else if (w_cnt_zero && !r_loop) begin
                        w_state_nxt = c_st_drain;
                    end
                end
            end
            c_st_drain: begin
                // Leave once the tagged sample / stop marker has been emitted
                if (rclke && w_tag_out) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (busy flag and read-issue request)
    // ------------------------------------------------------------------------
    always_comb begin
        busy         = (r_state != c_st_idle);
        w_issue      = 1'b0;
        w_issue_addr = raddr;
        w_issue_tag  = 1'b0;
        case (r_state)
            c_st_idle: begin
                // Random access only when idle and not in playback mode
                if (read_en && !mode) begin
                    w_issue = 1'b1;
                end
            end
            c_st_run: begin
                if (stop) begin
                    // No read this cycle; a data-less tagged marker is sent
                    // down the pipeline so done lines up with in-flight data.
                    w_issue_tag = 1'b1;
                end else begin
                    w_issue      = 1'b1;
                    w_issue_addr = r_ptr;
                    w_issue_tag  = w_cnt_zero && !r_loop;
                end
            end
            default: begin
                w_issue = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Playback pointer and remaining-count registers. Pointer arithmetic is
    // modulo 2^ADDR_W, so a window crossing the top of memory wraps to 0.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_cnt  <= '0;
            r_base <= '0;
            r_len  <= '0;
            r_loop <= 1'b0;
        end else if (rclke) begin
            case (r_state)
                c_st_idle: begin
                    if (start && mode) begin
                        r_base <= base;
                        r_len  <= len;
                        r_loop <= loop;
                        r_ptr  <= base;
                        r_cnt  <= len;
                    end
                end
                c_st_run: begin
                    if (!stop) begin
                        if (w_cnt_zero && r_loop) begin
                            // Reload for a gap-free restart of the window
                            r_ptr <= r_base;
                            r_cnt <= r_len;
                        end else begin
                            r_ptr <= r_ptr + c_one;
                            r_cnt <= r_cnt - c_one;
                        end
                    end
                end
                default: begin
                    r_ptr <= r_ptr;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read stage 1. The non-blocking read of r_mem sees the pre-write word
    // when the same address is written this cycle (read-first behaviour).
    // Data only updates on an issue so dout holds between samples.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_tag   <= 1'b0;
            r_s1_data  <= '0;
        end else if (rclke) begin
            r_s1_valid <= w_issue;
            r_s1_tag   <= w_issue_tag;
            if (w_issue) begin
                r_s1_data <= r_mem[w_issue_addr];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional output register stage
    // ------------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_s2_valid;
            logic              r_s2_tag;
            logic [DATA_W-1:0] r_s2_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2_valid <= 1'b0;
                    r_s2_tag   <= 1'b0;
                    r_s2_data  <= '0;
                end else if (rclke) begin
                    r_s2_valid <= r_s1_valid;
                    r_s2_tag   <= r_s1_tag;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign dout       = r_s2_data;
            assign dout_valid = r_s2_valid;
            assign w_tag_out  = r_s2_tag;
        end else begin : g_no_out_reg
            assign dout       = r_s1_data;
            assign dout_valid = r_s1_valid;
            assign w_tag_out  = r_s1_tag;
        end
    endgenerate

    // The tag exits the pipeline exactly once per playback: with the last
    // sample, or alone (dout_valid=0) when playback was stopped.
    assign done = w_tag_out;

endmodule
`default_nettype wire
